final_logic: RTL and testbench
==============================

FINAL_LOGIC -- requirements
Module: final_logic

Interface
REQ-001 SHALL have parameter data_width, default 6, word width of VC FIFO and output data.
REQ-002 SHALL have parameter DEST_BIT, default 4, index of the destination-select bit in each word (0 -> D0, 1 -> D1).
REQ-003 SHALL have parameter VC0_WEIGHT, default 3, maximum consecutive VC0 grants while VC1 is waiting.
REQ-004 SHALL have one clock and a synchronous active-low reset: `clk` is an input, width 1, rising-edge clock; `reset` is an input, width 1, active-low, sampled on `clk`.
REQ-005 SHALL have the VC0 FIFO read side:
- `data_out_VC0`: input, data_width, registered read data from the VC0 FIFO.
- `empty_fifo_VC0`: input, 1 bit.
- `almost_empty_fifo_VC0`: input, 1 bit, asserted when the FIFO holds 1 word or fewer.
- `pop_VC0_fifo`: output, 1 bit.
REQ-006 SHALL have the VC1 FIFO read side, identical to REQ-005: `data_out_VC1`, `empty_fifo_VC1`, `almost_empty_fifo_VC1`, `pop_VC1_fifo`.
REQ-007 SHALL have the destination FIFO inputs `almost_full_fifo_D0` and `almost_full_fifo_D1`, each input, 1 bit, back-pressure.
REQ-008 SHALL have the outputs `push_D0` and `push_D1`, each output, 1 bit, and `data_out_D0` and `data_out_D1`, each output, data_width.
REQ-009 SHALL have the output `state`, 2 bits, current FSM state for debug.

Function
REQ-010 SHALL implement the FSM states RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- While reset is low: RESET.
- First cycle after release: INIT.
- INIT -> IDLE unconditionally.
- IDLE -> ACTIVE when a pop is eligible.
- ACTIVE -> IDLE when no pop is eligible.
REQ-011 SHALL make VCx eligible when `!empty_fifo_VCx && !(pop_VCx_q && almost_empty_fifo_VCx) && !almost_full_fifo_D0 && !almost_full_fifo_D1`, where pop_VCx_q is the previous cycle's pop.
REQ-012 SHALL assert at most one pop per cycle, and only in IDLE or ACTIVE with the pop eligible; pops are combinational from state and inputs.
REQ-013 SHALL arbitrate with VC0 priority using a weight counter wcnt (0..VC0_WEIGHT):
- When both are eligible and wcnt < VC0_WEIGHT: grant VC0 and increment wcnt.
- When both are eligible and wcnt == VC0_WEIGHT: grant VC1 and clear wcnt.
- When only one is eligible: grant it; a VC1 grant clears wcnt, a VC0 grant leaves wcnt unchanged.
REQ-014 SHALL register a valid bit and a source bit on the pop cycle N, select `data_out_VCsrc` in N+1, and register it to `data_out_Dd` with `push_Dd`=1 visible in N+2, where d = word[DEST_BIT]; pop-to-push latency is exactly 2 cycles.
REQ-015 SHALL assert at most one of `push_D0`/`push_D1` per cycle; each push is a 1-cycle pulse per popped word.
REQ-016 SHALL hold `data_out_D0`/`data_out_D1` at their last pushed value when not pushing.
REQ-017 SHALL complete in-flight words (up to 2) even when almost_full asserts; the downstream almost_full threshold must leave 2 free slots.
REQ-018 SHALL, on simultaneous almost_full and eligibility, issue no pop; wcnt is unchanged.

Reset
REQ-019 SHALL, on reset low at a `clk` edge:
- Set `pop_VC0_fifo`, `pop_VC1_fifo`, `push_D0`, `push_D1` to 0.
- Set `data_out_D0`, `data_out_D1` to 0.
- Set wcnt, valid and source pipeline regs to 0.
- Set state to RESET.
REQ-020 SHALL, on reset mid-operation, drop in-flight words without pushing them.
REQ-021 SHALL clear wcnt and counters again in INIT.

Configuration
REQ-022 SHALL, with FINAL_COUNTERS_EN defined, add outputs `cnt_D0` and `cnt_D1`, each 8 bits, counting pushes per destination, saturating at 255, cleared by reset and INIT.
REQ-023 SHALL, without FINAL_COUNTERS_EN, have neither the ports nor the logic present.

Structure
REQ-024 SHALL take data_width default, FSM state encodings and the DEST_BIT default from the shared package pci_tl_pkg.
REQ-025 SHALL implement the weighted grant logic (REQ-013, wcnt) in a sub-module vc_arbiter; routing pipeline and FSM stay in final_logic.

Verification
REQ-026 SHALL have the bench cover these directed scenarios:
- Reset low 3 cycles, then high: all outputs 0; state goes 0 -> 1 -> 2.
- VC0 holds 0x15 (bit4=1), VC1 empty: pop_VC0 in cycle N; push_D1=1 with data_out_D1=0x15 in N+2; push_D0 stays 0.
- Both VCs hold 8 words, VC0_WEIGHT=3: grant sequence 0,0,0,1,0,0,0,1.
- almost_full_fifo_D0 raised one cycle after a pop: no further pops; exactly 1 in-flight push still occurs; pops resume the cycle after deassertion.
- VC0 holds 1 word, almost_empty=1: single pop and no underflow pop the next cycle.
- Reset asserted the cycle after a pop: no push follows; with FINAL_COUNTERS_EN, cnt_D0=cnt_D1=0; 300 pushes to D0 leave cnt_D0=255.

Source files
------------

// File: rtl/pci_tl_pkg.sv
// pci_tl_pkg: shared widths, FSM encodings and helpers for the TL final routing stage
package pci_tl_pkg;
    localparam int DATA_WIDTH_DEFAULT = 6;
    localparam int DEST_BIT_DEFAULT = 4;
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_IDLE = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;
    typedef enum logic {SRC_VC0 = 1'b0, SRC_VC1 = 1'b1} src_e;
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/final_logic_if.sv
// final_logic_if: VC FIFO read sides and destination push sides of final_logic
interface final_logic_if
    import pci_tl_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEFAULT
) ();
    logic [data_width-1:0] data_out_VC0;
    logic [data_width-1:0] data_out_VC1;
    logic empty_fifo_VC0;
    logic empty_fifo_VC1;
    logic almost_empty_fifo_VC0;
    logic almost_empty_fifo_VC1;
    logic pop_VC0_fifo;
    logic pop_VC1_fifo;
    logic almost_full_fifo_D0;
    logic almost_full_fifo_D1;
    logic push_D0;
    logic push_D1;
    logic [data_width-1:0] data_out_D0;
    logic [data_width-1:0] data_out_D1;
    modport slave (
        input  data_out_VC0, data_out_VC1, empty_fifo_VC0, empty_fifo_VC1,
        input  almost_empty_fifo_VC0, almost_empty_fifo_VC1,
        input  almost_full_fifo_D0, almost_full_fifo_D1,
        output pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_D0, data_out_D1
    );
    modport master (
        output data_out_VC0, data_out_VC1, empty_fifo_VC0, empty_fifo_VC1,
        output almost_empty_fifo_VC0, almost_empty_fifo_VC1,
        output almost_full_fifo_D0, almost_full_fifo_D1,
        input  pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_D0, data_out_D1
    );
endinterface

// File: rtl/final_logic_vc_arbiter.sv
// vc_arbiter: weighted VC0-priority grant between the two virtual channels
module vc_arbiter #(
    parameter int VC0_WEIGHT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    input  logic elig0_i,
    input  logic elig1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    localparam int CW = (VC0_WEIGHT > 0) ? $clog2(VC0_WEIGHT + 1) : 1;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic turn1;
    // VC1 takes the slot once VC0 has used its consecutive-grant budget while VC1 waited
    always_comb begin
        turn1 = wcnt_q == CW'(VC0_WEIGHT);
        gnt0_o = en_i && elig0_i && !(elig1_i && turn1);
        gnt1_o = en_i && elig1_i && !(elig0_i && !turn1);
        wcnt_d = gnt1_o ? '0 : (gnt0_o && elig1_i) ? wcnt_q + 1'b1 : wcnt_q;
    end
    // weight counter, restarted by reset and by the INIT state
    always_ff @(posedge clk) begin
        if (!reset || clr_i) wcnt_q <= '0;
        else wcnt_q <= wcnt_d;
    end
endmodule

// File: rtl/final_logic.sv
// final_logic: pops two VC FIFOs by weighted arbitration and routes words to D0/D1; FINAL_COUNTERS_EN adds push counters
module final_logic
    import pci_tl_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEFAULT,
    parameter int DEST_BIT = DEST_BIT_DEFAULT,
    parameter int VC0_WEIGHT = 3
) (
    input  logic clk,
    input  logic reset,
    final_logic_if.slave bus,
`ifdef FINAL_COUNTERS_EN
    output logic [7:0] cnt_D0,
    output logic [7:0] cnt_D1,
`endif
    output logic [1:0] state
);
    logic [1:0] state_q, state_d;
    logic pop0_q, pop1_q, valid_q;
    src_e src_q;
    logic run, elig0, elig1, gnt0, gnt1;
    logic [data_width-1:0] word, data_d0_q, data_d1_q;
    logic push_d0_q, push_d1_q, push_d0_d, push_d1_d;
    // a channel may pop when it has data, cannot underflow and both destinations have room
    always_comb begin
        run = reset && (state_q == ST_IDLE || state_q == ST_ACTIVE);
        elig0 = !bus.empty_fifo_VC0 && !(pop0_q && bus.almost_empty_fifo_VC0) && !bus.almost_full_fifo_D0 && !bus.almost_full_fifo_D1;
        elig1 = !bus.empty_fifo_VC1 && !(pop1_q && bus.almost_empty_fifo_VC1) && !bus.almost_full_fifo_D0 && !bus.almost_full_fifo_D1;
    end
    vc_arbiter #(.VC0_WEIGHT(VC0_WEIGHT)) u_arb (
        .clk(clk),
        .reset(reset),
        .clr_i(state_q == ST_INIT),
        .en_i(run),
        .elig0_i(elig0),
        .elig1_i(elig1),
        .gnt0_o(gnt0),
        .gnt1_o(gnt1)
    );
    // RESET -> INIT -> IDLE, then IDLE/ACTIVE track whether any channel can pop
    always_comb begin
        state_d = (state_q == ST_RESET) ? ST_INIT : (state_q == ST_INIT) ? ST_IDLE : (elig0 || elig1) ? ST_ACTIVE : ST_IDLE;
    end
    // the popped word appears on the FIFO read port one cycle after the pop; route it by its destination bit
    always_comb begin
        word = (src_q == SRC_VC1) ? bus.data_out_VC1 : bus.data_out_VC0;
        push_d1_d = valid_q && word[DEST_BIT];
        push_d0_d = valid_q && !word[DEST_BIT];
    end
    // state, pop history and the two-stage routing pipeline; reset drops words in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RESET;
            pop0_q <= 1'b0;
            pop1_q <= 1'b0;
            valid_q <= 1'b0;
            src_q <= SRC_VC0;
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            data_d0_q <= '0;
            data_d1_q <= '0;
        end else begin
            state_q <= state_d;
            pop0_q <= gnt0;
            pop1_q <= gnt1;
            valid_q <= gnt0 || gnt1;
            src_q <= gnt1 ? SRC_VC1 : SRC_VC0;
            push_d0_q <= push_d0_d;
            push_d1_q <= push_d1_d;
            if (push_d0_d) data_d0_q <= word;
            if (push_d1_d) data_d1_q <= word;
        end
    end
`ifdef FINAL_COUNTERS_EN
    logic [7:0] cnt_d0_q, cnt_d1_q;
    // saturating per-destination push counters, restarted by reset and INIT
    always_ff @(posedge clk) begin
        if (!reset || state_q == ST_INIT) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            if (push_d0_d) cnt_d0_q <= sat_inc8(cnt_d0_q);
            if (push_d1_d) cnt_d1_q <= sat_inc8(cnt_d1_q);
        end
    end
    assign cnt_D0 = cnt_d0_q;
    assign cnt_D1 = cnt_d1_q;
`endif
    assign bus.pop_VC0_fifo = gnt0;
    assign bus.pop_VC1_fifo = gnt1;
    assign bus.push_D0 = push_d0_q;
    assign bus.push_D1 = push_d1_q;
    assign bus.data_out_D0 = data_d0_q;
    assign bus.data_out_D1 = data_d1_q;
    assign state = state_q;
endmodule

// File: tb/tb_final_logic.sv
// tb_final_logic: directed and random stimulus against a queue-based reference model of final_logic
module tb_final_logic;
    localparam int W = 6;
    localparam int DB = 4;
    localparam int VW = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] state;
`ifdef FINAL_COUNTERS_EN
    logic [7:0] cnt_D0, cnt_D1;
    int mc0 = 0, mc1 = 0;
`endif
    final_logic_if #(.data_width(W)) bus ();
    final_logic #(.data_width(W), .DEST_BIT(DB), .VC0_WEIGHT(VW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
`ifdef FINAL_COUNTERS_EN
        .cnt_D0(cnt_D0),
        .cnt_D1(cnt_D1),
`endif
        .state(state)
    );
    always #5 clk = ~clk;

    typedef struct {int due; logic [W-1:0] w;} pend_t;
    logic [W-1:0] q0[$], q1[$];
    pend_t pend[$];
    int glog[$];
    int seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int checks = 0, errors = 0, cyc = 0;
    int m_state = 0, m_wcnt = 0;
    int n_pops = 0, n_push = 0;
    bit m_p0 = 0, m_p1 = 0;
    logic af0 = 1'b0, af1 = 1'b0;
    logic [W-1:0] last0 = '0, last1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.empty_fifo_VC0 = q0.size() == 0;
        bus.empty_fifo_VC1 = q1.size() == 0;
        bus.almost_empty_fifo_VC0 = q0.size() <= 1;
        bus.almost_empty_fifo_VC1 = q1.size() <= 1;
        bus.almost_full_fifo_D0 = af0;
        bus.almost_full_fifo_D1 = af1;
    endtask

    // one clock: check every output against the model, then advance model and FIFOs
    task automatic step();
        bit e0, e1, g0, g1, x0, x1, o0, o1;
        drive();
        @(negedge clk);
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        e0 = q0.size() > 0 && !(m_p0 && q0.size() <= 1) && !af0 && !af1;
        e1 = q1.size() > 0 && !(m_p1 && q1.size() <= 1) && !af0 && !af1;
        g0 = 0;
        g1 = 0;
        if (reset && m_state >= 2) begin
            if (e0 && e1) begin
                g1 = m_wcnt == VW;
                g0 = !g1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
        end
        x0 = 0;
        x1 = 0;
        foreach (pend[i]) if (pend[i].due == cyc) begin
            if (pend[i].w[DB]) begin x1 = 1; last1 = pend[i].w; end
            else begin x0 = 1; last0 = pend[i].w; end
        end
        o0 = bus.pop_VC0_fifo;
        o1 = bus.pop_VC1_fifo;
        chk("state", 32'(state), 32'(m_state));
        chk("pop_VC0", 32'(o0), 32'(g0));
        chk("pop_VC1", 32'(o1), 32'(g1));
        chk("push_D0", 32'(bus.push_D0), 32'(x0));
        chk("push_D1", 32'(bus.push_D1), 32'(x1));
        chk("data_D0", 32'(bus.data_out_D0), 32'(last0));
        chk("data_D1", 32'(bus.data_out_D1), 32'(last1));
`ifdef FINAL_COUNTERS_EN
        if (x0 && mc0 < 255) mc0++;
        if (x1 && mc1 < 255) mc1++;
        chk("cnt_D0", 32'(cnt_D0), 32'(mc0));
        chk("cnt_D1", 32'(cnt_D1), 32'(mc1));
`endif
        if (o0) glog.push_back(0);
        if (o1) glog.push_back(1);
        n_pops += int'(o0) + int'(o1);
        n_push += int'(bus.push_D0) + int'(bus.push_D1);
        if (!reset) begin
            m_state = 0;
            m_p0 = 0;
            m_p1 = 0;
            m_wcnt = 0;
            pend.delete();
            last0 = '0;
            last1 = '0;
`ifdef FINAL_COUNTERS_EN
            mc0 = 0;
            mc1 = 0;
`endif
        end else begin
            if (g0) pend.push_back('{cyc + 2, q0[0]});
            if (g1) pend.push_back('{cyc + 2, q1[0]});
            if (g1) m_wcnt = 0;
            else if (g0 && e1) m_wcnt++;
            m_p0 = g0;
            m_p1 = g1;
            m_state = (m_state == 0) ? 1 : (m_state == 1) ? 2 : (e0 || e1) ? 3 : 2;
        end
        @(posedge clk);
        #1;
        if (o0 && q0.size() > 0) bus.data_out_VC0 = q0.pop_front();
        if (o1 && q1.size() > 0) bus.data_out_VC1 = q1.pop_front();
        cyc++;
        drive();
    endtask

    task automatic wait_pop(input string tag);
        int n;
        n = n_pops;
        for (int k = 0; k < 20 && n_pops == n; k++) step();
        chk(tag, 32'(n_pops != n), 32'd1);
    endtask

    initial begin
        bus.data_out_VC0 = '0;
        bus.data_out_VC1 = '0;
        drive();
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        q0.push_back(6'h15);
        wait_pop("pop_0x15");
        repeat (2) step();
        chk("d1_0x15", 32'(bus.data_out_D1), 32'h15);
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(W'(i + 1));
            q1.push_back(W'(6'h20 + i));
        end
        glog.delete();
        repeat (10) step();
        chk("grant_count", 32'(glog.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("grant_seq", 32'(glog[i]), 32'(seq[i]));
        repeat (20) step();
        for (int i = 0; i < 4; i++) q0.push_back(W'(6'h08 + i));
        wait_pop("pop_before_af");
        af0 = 1'b1;
        n_pops = 0;
        n_push = 0;
        repeat (4) step();
        chk("af_pops", 32'(n_pops), 32'd0);
        chk("af_inflight", 32'(n_push), 32'd1);
        af0 = 1'b0;
        n_pops = 0;
        step();
        chk("af_resume", 32'(n_pops), 32'd1);
        repeat (12) step();
        q0.push_back(6'h2A);
        n_pops = 0;
        repeat (4) step();
        chk("single_pop", 32'(n_pops), 32'd1);
        repeat (3) step();
        q0.push_back(6'h03);
        wait_pop("pop_before_rst");
        reset = 1'b0;
        n_push = 0;
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("dropped_push", 32'(n_push), 32'd0);
`ifdef FINAL_COUNTERS_EN
        chk("cnt_D0_rst", 32'(cnt_D0), 32'd0);
        chk("cnt_D1_rst", 32'(cnt_D1), 32'd0);
        for (int i = 0; i < 300; i++) q0.push_back(W'($urandom) & 6'h2F);
        repeat (320) step();
        chk("cnt_D0_sat", 32'(cnt_D0), 32'd255);
`endif
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) q0.push_back(W'($urandom));
            if ($urandom_range(0, 2) == 0) q1.push_back(W'($urandom));
            af0 = $urandom_range(0, 7) == 0;
            af1 = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 99) != 0;
            step();
        end
        reset = 1'b1;
        af0 = 1'b0;
        af1 = 1'b0;
        repeat (30) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
